// File: rtl/serial_tape_feed.sv
// serial_tape_feed
//   Streams a byte sequence (paper-tape / BIN loader image) from an upstream
//   valid/ready source into the CPU keyboard receive line as 8N1 serial, so a
//   program can be booted without an external terminal. Optionally watches the
//   CPU printer transmit line for XOFF/XON to pace the stream.
//
// Parameters
//   CLK_DIV   clocks per serial bit (>= 4)
//   GAP_BITS  idle bit-times appended after each stop bit (0..15)
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous active-high reset
//   i_start        pulse: begin a stream (ignored unless idle)
//   i_abort        pulse: stop streaming immediately (wins over i_start)
//   i_data         byte to send, [0:7] with bit 7 the LSB
//   i_data_valid   i_data holds a byte
//   i_data_last    marks the final byte of the stream
//   o_data_ready   byte accepted this cycle when valid
//   o_tx_line      serial out to the CPU keyboard rx, idles high
//   i_rx_line      serial in from the CPU printer tx (asynchronous)
//   o_busy         stream in progress
//   o_paused       XOFF in effect
//   o_char_count   characters fully sent in the current stream
//   o_done         one-cycle pulse at normal end of stream
//
// Build option
//   SERIAL_FEED_XONXOFF_EN  when defined, builds the XOFF/XON receiver and pause
//                           logic; otherwise i_rx_line is unused, o_paused is 0.

module serial_tape_feed #(
    parameter int unsigned CLK_DIV  = 10417,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [0:7]  i_data,
    input  logic        i_data_valid,
    input  logic        i_data_last,
    output logic        o_data_ready,
    output logic        o_tx_line,
    input  logic        i_rx_line,
    output logic        o_busy,
    output logic        o_paused,
    output logic [0:11] o_char_count,
    output logic        o_done
);

    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] BitLoad = TW'(CLK_DIV - 1);
    localparam logic [3:0]    GapLoad = 4'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StStart,
        StData,
        StStop,
        StGap
    } state_e;

    state_e         r_state;
    logic [TW-1:0]  r_timer;
    logic [3:0]     r_bit_cnt;
    logic [0:7]     r_byte;
    logic           r_last;
    logic           r_tx;
    logic           r_done;
    logic [0:11]    r_char_count;

    // Pause value after this cycle's XOFF/XON resolution, so a character that
    // completes in the same cycle as the pause update sees the new value.
    logic           w_paused_nxt;
    logic           w_data_ready;

`ifdef SERIAL_FEED_XONXOFF_EN
    localparam logic [TW-1:0] HalfLoad = TW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    rx_state_e      r_rx_state;
    logic           r_rx_meta;
    logic           r_rx_sync;
    logic           r_rx_prev;
    logic [TW-1:0]  r_rx_timer;
    logic [2:0]     r_rx_cnt;
    logic [7:0]     r_rx_shift;
    logic           r_paused;

    logic           w_rx_frame_ok;
    logic           w_xoff_hit;
    logic           w_xon_hit;

    // Stop bit sampled high completes a good frame; the MSB (parity/mark) is
    // ignored in the compare.
    assign w_rx_frame_ok = (r_rx_state == RxStop) && (r_rx_timer == '0) && r_rx_sync;
    assign w_xoff_hit    = w_rx_frame_ok && (r_rx_shift[6:0] == 7'h13);
    assign w_xon_hit     = w_rx_frame_ok && (r_rx_shift[6:0] == 7'h11);
    assign w_paused_nxt  = w_xoff_hit ? 1'b1 : (w_xon_hit ? 1'b0 : r_paused);
    assign o_paused      = r_paused;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RxIdle;
            r_rx_timer <= '0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_paused   <= 1'b0;
        end else begin
            r_rx_meta <= i_rx_line;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_paused  <= w_paused_nxt;
            case (r_rx_state)
                RxIdle: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_timer <= HalfLoad;
                        r_rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    if (r_rx_timer == '0) begin
                        // Glitch rejection: start bit must still be low mid-bit.
                        if (!r_rx_sync) begin
                            r_rx_timer <= BitLoad;
                            r_rx_cnt   <= '0;
                            r_rx_state <= RxData;
                        end else begin
                            r_rx_state <= RxIdle;
                        end
                    end else begin
                        r_rx_timer <= r_rx_timer - 1'b1;
                    end
                end
                RxData: begin
                    if (r_rx_timer == '0) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_timer <= BitLoad;
                        if (r_rx_cnt == 3'd7) begin
                            r_rx_state <= RxStop;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 3'd1;
                        end
                    end else begin
                        r_rx_timer <= r_rx_timer - 1'b1;
                    end
                end
                RxStop: begin
                    if (r_rx_timer == '0) begin
                        r_rx_state <= RxIdle;
                    end else begin
                        r_rx_timer <= r_rx_timer - 1'b1;
                    end
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end
`else
    logic w_unused_rx;

    assign w_unused_rx  = i_rx_line;
    assign w_paused_nxt = 1'b0;
    assign o_paused     = 1'b0;
`endif

    assign w_data_ready = (r_state == StWaitData) && !w_paused_nxt;
    assign o_data_ready = w_data_ready;
    assign o_busy       = (r_state != StIdle);
    assign o_tx_line    = r_tx;
    assign o_done       = r_done;
    assign o_char_count = r_char_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_bit_cnt    <= '0;
            r_byte       <= '0;
            r_last       <= 1'b0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
            r_char_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                // Truncated character is dropped; char_count is left as is.
                r_state   <= StIdle;
                r_tx      <= 1'b1;
                r_timer   <= '0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_char_count <= '0;
                            r_state      <= StWaitData;
                        end
                    end
                    StWaitData: begin
                        if (i_data_valid && w_data_ready) begin
                            r_byte  <= i_data;
                            r_last  <= i_data_last;
                            r_tx    <= 1'b0;
                            r_timer <= BitLoad;
                            r_state <= StStart;
                        end
                    end
                    StStart: begin
                        if (r_timer == '0) begin
                            // r_byte[7] is the LSB; shift toward index 7.
                            r_tx      <= r_byte[7];
                            r_byte    <= {1'b0, r_byte[0:6]};
                            r_bit_cnt <= '0;
                            r_timer   <= BitLoad;
                            r_state   <= StData;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    StData: begin
                        if (r_timer == '0) begin
                            r_timer <= BitLoad;
                            if (r_bit_cnt == 4'd7) begin
                                r_tx    <= 1'b1;
                                r_state <= StStop;
                            end else begin
                                r_tx      <= r_byte[7];
                                r_byte    <= {1'b0, r_byte[0:6]};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    StStop: begin
                        if (r_timer == '0) begin
                            r_char_count <= r_char_count + 12'd1;
                            if (GAP_BITS == 0) begin
                                r_done  <= r_last;
                                r_state <= r_last ? StIdle : StWaitData;
                            end else begin
                                r_timer   <= BitLoad;
                                r_bit_cnt <= GapLoad;
                                r_state   <= StGap;
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    StGap: begin
                        if (r_timer == '0) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_done  <= r_last;
                                r_state <= r_last ? StIdle : StWaitData;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                                r_timer   <= BitLoad;
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_tape_feed.sv
// Bench for serial_tape_feed: each accepted byte is expanded into its ideal
// 8N1 frame (start 0, LSB..MSB, stop 1) held CLK_DIV cycles per bit, followed
// by GAP_BITS idle bit-times, and compared cycle by cycle against o_tx_line.
module tb_serial_tape_feed;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned GAP_BITS = 2;
    localparam int unsigned FRAME_T  = 10 * CLK_DIV;
    localparam int unsigned GAP_T    = GAP_BITS * CLK_DIV;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [0:7]  data;
    logic        valid;
    logic        last;
    logic        rx;
    logic        ready;
    logic        tx;
    logic        busy;
    logic        paused;
    logic [0:11] cnt;
    logic        done;

    int unsigned n_compared = 0;
    int unsigned n_mismatch = 0;

    always #5 clk = ~clk;

    serial_tape_feed #(
        .CLK_DIV  (CLK_DIV),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_abort      (abort),
        .i_data       (data),
        .i_data_valid (valid),
        .i_data_last  (last),
        .o_data_ready (ready),
        .o_tx_line    (tx),
        .i_rx_line    (rx),
        .o_busy       (busy),
        .o_paused     (paused),
        .o_char_count (cnt),
        .o_done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 character onto rx, each bit CLK_DIV clocks.
    task automatic rx_send(input logic [7:0] ch, input logic stop_bit);
        logic fr [10];
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = ch[i];
        fr[9] = stop_bit;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic wait_paused(input logic want, input string tag);
        for (int t = 0; t < 16 && paused !== want; t++) tick();
        check_eq(tag, paused, want);
    endtask

    // brk_mode: 0 none, 1 abort at frame cycle brk_at, 2 async reset there.
    task automatic send_byte(input logic [7:0] b, input bit is_last, input int unsigned cnt_before,
                             input int unsigned delay, input int brk_at, input int brk_mode);
        logic fb [10];
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
        fb[9] = 1'b1;
        data  = b;
        valid = 1'b0;
        last  = 1'b0;
        for (int d = 0; d < int'(delay); d++) begin
            check_eq("ready_wait", ready, 1);
            tick();
        end
        valid = 1'b1;
        last  = is_last;
        check_eq("ready_hs", ready, 1);
        tick();
        valid = 1'b0;
        last  = 1'b0;
        for (int i = 0; i < int'(FRAME_T); i++) begin
            if (i == brk_at && brk_mode == 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_eq("abort_tx", tx, 1);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_ready", ready, 0);
                check_eq("abort_cnt", cnt, cnt_before);
                for (int k = 0; k < 3 * int'(CLK_DIV); k++) begin
                    check_eq("abort_done", done, 0);
                    tick();
                end
                check_eq("abort_cnt_hold", cnt, cnt_before);
                return;
            end
            if (i == brk_at && brk_mode == 2) begin
                #1 reset = 1'b1;
                #1;
                check_eq("rst_tx", tx, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_ready", ready, 0);
                check_eq("rst_cnt", cnt, 0);
                check_eq("rst_done", done, 0);
                tick();
                reset = 1'b0;
                tick();
                check_eq("rst_idle", busy, 0);
                return;
            end
            check_eq("tx_bit", tx, fb[i / int'(CLK_DIV)]);
            check_eq("busy_frame", busy, 1);
            check_eq("done_frame", done, 0);
            tick();
        end
        check_eq("char_count", cnt, cnt_before + 1);
        for (int g = 0; g < int'(GAP_T); g++) begin
            check_eq("tx_gap", tx, 1);
            check_eq("ready_gap", ready, 0);
            check_eq("done_gap", done, 0);
            tick();
        end
        if (is_last) begin
            check_eq("done_pulse", done, 1);
            check_eq("busy_end", busy, 0);
            tick();
            check_eq("done_once", done, 0);
        end
    endtask

    task automatic run_bytes(input byte_q_t bs);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_cnt", cnt, 0);
        check_eq("start_ready", ready, 1);
        for (int k = 0; k < bs.size(); k++) begin
            send_byte(bs[k], k == bs.size() - 1, k, $urandom_range(0, 3), -1, 0);
        end
        check_eq("stream_cnt", cnt, bs.size());
        check_eq("stream_idle", busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t q;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        data  = '0;
        valid = 1'b0;
        last  = 1'b0;
        rx    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx_line", tx, 1);
        check_eq("rst_data_ready", ready, 0);
        check_eq("rst_busy_flag", busy, 0);
        check_eq("rst_paused", paused, 0);
        check_eq("rst_char_count", cnt, 0);
        check_eq("rst_done_flag", done, 0);
        reset = 1'b0;
        tick();

        q = '{8'h55};
        run_bytes(q);
        q = '{8'h41, 8'h42, 8'h43};
        run_bytes(q);

        // Abort together with start: abort wins.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_eq("abort_wins", busy, 0);

        // Abort during data bit 3 of the second character.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'hA7, 1'b0, 0, 1, -1, 0);
        send_byte(8'h3C, 1'b1, 1, 0, 4 * int'(CLK_DIV) + 1, 1);

        // Asynchronous reset in the middle of the start bit, then a clean stream.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h96, 1'b1, 0, 0, int'(CLK_DIV) / 2, 2);
        q = '{8'h5A, 8'hC3};
        run_bytes(q);

        for (int s = 0; s < 6; s++) begin
            int unsigned n;
            n = $urandom_range(1, 4);
            q = {};
            for (int k = 0; k < int'(n); k++) q.push_back(8'($urandom));
            run_bytes(q);
            repeat ($urandom_range(0, 5)) tick();
        end

`ifdef SERIAL_FEED_XONXOFF_EN
        // Framing error: stop bit low, character discarded.
        rx_send(8'h13, 1'b0);
        repeat (8) tick();
        check_eq("frame_err", paused, 0);
        // MSB ignored in the compare.
        rx_send(8'h93, 1'b1);
        wait_paused(1'b1, "xoff_parity");
        // Start does not clear pause.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("paused_start_busy", busy, 1);
        for (int t = 0; t < 5; t++) begin
            check_eq("paused_ready", ready, 0);
            tick();
        end
        rx_send(8'h91, 1'b1);
        wait_paused(1'b0, "xon_parity");
        check_eq("xon_ready", ready, 1);
        send_byte(8'h6E, 1'b1, 0, 1, -1, 0);

        // XOFF arrives while byte 1 of 3 is on the wire.
        start = 1'b1;
        tick();
        start = 1'b0;
        fork
            rx_send(8'h13, 1'b1);
        join_none
        send_byte(8'h31, 1'b0, 0, 0, -1, 0);
        check_eq("xoff_mid", paused, 1);
        data  = 8'h32;
        valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            check_eq("xoff_ready", ready, 0);
            check_eq("xoff_tx", tx, 1);
            tick();
        end
        valid = 1'b0;
        rx_send(8'h11, 1'b1);
        wait_paused(1'b0, "xon_mid");
        send_byte(8'h32, 1'b0, 1, 0, -1, 0);
        send_byte(8'h33, 1'b1, 2, 0, -1, 0);
        check_eq("xoff_stream_cnt", cnt, 3);
`else
        // Without the receiver, XOFF has no effect and the stream runs on.
        start = 1'b1;
        tick();
        start = 1'b0;
        fork
            rx_send(8'h13, 1'b1);
        join_none
        send_byte(8'h31, 1'b0, 0, 0, -1, 0);
        check_eq("no_xoff", paused, 0);
        send_byte(8'h32, 1'b1, 1, 0, -1, 0);
        check_eq("no_xoff_cnt", cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
